// File: rtl/dec_error_corrector_8bit.sv
// Correction stage of the extended Hamming (8,4) decoder: classifies each word
// from its syndrome, fixes single-bit errors and keeps saturating error counts.
module dec_error_corrector_8bit #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           in_codeword,
  input  logic [3:0]           in_syndrome,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [3:0]           out_data,
  output logic                 out_corrected,
  output logic                 out_uncorrectable,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 cnt_clear,
  output logic [CNT_WIDTH-1:0] corr_cnt,
  output logic [CNT_WIDTH-1:0] uncorr_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Handshake: a transfer happens on any edge where valid && ready; the whole
  // pipeline advances together whenever the output slot is empty or being taken.
  logic       w_advance;
  logic       w_out_hs;

  logic       r_valid_a;
  logic [7:0] r_cw_a;
  logic [3:0] r_syn_a;

  logic [3:0] r_data_b;
  logic       r_corr_b;
  logic       r_uncorr_b;
  logic       r_valid_b;

  logic [CNT_WIDTH-1:0] r_corr_cnt;
  logic [CNT_WIDTH-1:0] r_uncorr_cnt;

  logic [3:0] w_fix_mask;
  logic       w_corr;
  logic       w_uncorr;
  logic [3:0] w_data;

  assign w_advance = !r_valid_b || out_ready;
  assign w_out_hs  = r_valid_b && out_ready;
  assign in_ready  = w_advance;

  // Only errors on bits 3..0 touch the delivered nibble; bits 7..4 are check bits.
  always_comb begin
    w_fix_mask = 4'b0000;
    if (r_syn_a[0]) begin
      case (r_syn_a[3:1])
        3'b110:  w_fix_mask = 4'b1000;
        3'b101:  w_fix_mask = 4'b0100;
        3'b011:  w_fix_mask = 4'b0010;
        3'b111:  w_fix_mask = 4'b0001;
        default: w_fix_mask = 4'b0000;
      endcase
    end
  end

  assign w_corr   = r_syn_a[0];
  assign w_uncorr = !r_syn_a[0] && (r_syn_a[3:1] != 3'b000);
  assign w_data   = r_cw_a[3:0] ^ w_fix_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid_a  <= 1'b0;
      r_cw_a     <= 8'h00;
      r_syn_a    <= 4'h0;
      r_valid_b  <= 1'b0;
      r_data_b   <= 4'h0;
      r_corr_b   <= 1'b0;
      r_uncorr_b <= 1'b0;
    end else if (w_advance) begin
      r_valid_a  <= in_valid;
      r_cw_a     <= in_codeword;
      r_syn_a    <= in_syndrome;
      r_valid_b  <= r_valid_a;
      r_data_b   <= w_data;
      r_corr_b   <= w_corr;
      r_uncorr_b <= w_uncorr;
    end
  end

  // Clear wins over a same-cycle delivery, which is then simply not counted.
  always_ff @(posedge clk) begin
    if (rst || cnt_clear) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else if (w_out_hs) begin
      if (r_corr_b && (r_corr_cnt != CNT_MAX)) begin
        r_corr_cnt <= r_corr_cnt + CNT_ONE;
      end
      if (r_uncorr_b && (r_uncorr_cnt != CNT_MAX)) begin
        r_uncorr_cnt <= r_uncorr_cnt + CNT_ONE;
      end
    end
  end

  assign out_data          = r_data_b;
  assign out_corrected     = r_corr_b;
  assign out_uncorrectable = r_uncorr_b;
  assign out_valid         = r_valid_b;
  assign corr_cnt          = r_corr_cnt;
  assign uncorr_cnt        = r_uncorr_cnt;

endmodule

// File: tb/tb_dec_error_corrector_8bit.sv
// Directed bench for dec_error_corrector_8bit; a second instance with 2-bit
// counters shares the stimulus so saturation can be observed.
module tb_dec_error_corrector_8bit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_codeword = 8'h00;
  logic [3:0]  in_syndrome = 4'h0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        cnt_clear = 1'b0;

  logic        in_ready, out_corrected, out_uncorrectable, out_valid;
  logic [3:0]  out_data;
  logic [15:0] corr_cnt, uncorr_cnt;

  logic        in_ready_s, out_corrected_s, out_uncorrectable_s, out_valid_s;
  logic [3:0]  out_data_s;
  logic [1:0]  corr_cnt_s, uncorr_cnt_s;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [5:0]  exp_q[$];
  int          acc_q[$];
  logic [5:0]  pend_exp = 6'h00;
  logic        lat_chk = 1'b0;
  logic        prev_stall = 1'b0;
  logic [6:0]  prev_out = 7'h00;
  logic [0:19] bp_pat = 20'b1001_0110_0101_1111_1111;
  logic [1:0]  sat_exp[0:4] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  dec_error_corrector_8bit #(.CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .in_codeword(in_codeword), .in_syndrome(in_syndrome),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_corrected(out_corrected), .out_uncorrectable(out_uncorrectable),
    .out_valid(out_valid), .out_ready(out_ready), .cnt_clear(cnt_clear),
    .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  dec_error_corrector_8bit #(.CNT_WIDTH(2)) u_sat (
    .clk(clk), .rst(rst), .in_codeword(in_codeword), .in_syndrome(in_syndrome),
    .in_valid(in_valid), .in_ready(in_ready_s), .out_data(out_data_s),
    .out_corrected(out_corrected_s), .out_uncorrectable(out_uncorrectable_s),
    .out_valid(out_valid_s), .out_ready(out_ready), .cnt_clear(cnt_clear),
    .corr_cnt(corr_cnt_s), .uncorr_cnt(uncorr_cnt_s)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] cw, input logic [3:0] syn, input logic [5:0] exp);
    logic got;
    got = 1'b0;
    pend_exp    = exp;
    in_codeword = cw;
    in_syndrome = syn;
    in_valid    = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    check("accept", got, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 100; n++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check("drain", exp_q.size(), 0);
    tick();
  endtask

  // scoreboard: expected {data, corrected, uncorrectable} per accepted word
  always @(negedge clk) begin
    logic [5:0] e;
    int a;
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
      prev_stall = 1'b0;
    end else begin
      check("in_ready", in_ready, !(out_valid && !out_ready));
      if (prev_stall)
        check("stall_hold", {out_valid, out_data, out_corrected, out_uncorrectable}, prev_out);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_word", out_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("out_word", {out_data, out_corrected, out_uncorrectable}, e);
          if (lat_chk) check("latency", cyc - a, 2);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(pend_exp);
        acc_q.push_back(cyc);
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_valid, out_data, out_corrected, out_uncorrectable};
    end
  end

  initial begin
    // reset state
    tick();
    tick();
    rst = 1'b0;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 4'h0);
    check("rst_flags", {out_corrected, out_uncorrectable}, 2'b00);
    check("rst_corr_cnt", corr_cnt, 16'd0);
    check("rst_uncorr_cnt", uncorr_cnt, 16'd0);
    check("rst_in_ready", in_ready, 1'b1);

    // clean stream, back-to-back
    lat_chk = 1'b1;
    send(8'h3C, 4'b0000, {4'hC, 2'b00});
    send(8'h5A, 4'b0000, {4'hA, 2'b00});
    send(8'hF7, 4'b0000, {4'h7, 2'b00});
    send(8'h01, 4'b0000, {4'h1, 2'b00});
    drain();
    lat_chk = 1'b0;
    check("clean_corr_cnt", corr_cnt, 16'd0);
    check("clean_uncorr_cnt", uncorr_cnt, 16'd0);

    // single-error sweep on 0000_1011
    send(8'h0B, 4'b1001, {4'b1011, 2'b10});
    send(8'h0B, 4'b0101, {4'b1011, 2'b10});
    send(8'h0B, 4'b0011, {4'b1011, 2'b10});
    send(8'h0B, 4'b1111, {4'b1010, 2'b10});
    send(8'h0B, 4'b1101, {4'b0011, 2'b10});
    send(8'h0B, 4'b1011, {4'b1111, 2'b10});
    send(8'h0B, 4'b0111, {4'b1001, 2'b10});
    send(8'h0B, 4'b0001, {4'b1011, 2'b10});
    drain();
    check("sweep_corr_cnt", corr_cnt, 16'd8);
    check("sweep_uncorr_cnt", uncorr_cnt, 16'd0);

    // double error
    send(8'hA5, 4'b0110, {4'h5, 2'b01});
    drain();
    check("dbl_uncorr_cnt", uncorr_cnt, 16'd1);
    check("dbl_corr_cnt", corr_cnt, 16'd8);

    // backpressure with toggling out_ready
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          out_ready = bp_pat[i];
          tick();
        end
        out_ready = 1'b1;
      end
      begin
        send(8'h11, 4'b0000, {4'h1, 2'b00});
        send(8'h22, 4'b0000, {4'h2, 2'b00});
        send(8'h33, 4'b0000, {4'h3, 2'b00});
        send(8'h44, 4'b0000, {4'h4, 2'b00});
        send(8'h55, 4'b0000, {4'h5, 2'b00});
      end
    join
    drain();

    // clear, then saturate the 2-bit counter
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    check("clr_corr_cnt", corr_cnt, 16'd0);
    check("clr_uncorr_cnt", uncorr_cnt, 16'd0);
    check("clr_corr_cnt_s", corr_cnt_s, 2'd0);
    for (int i = 0; i < 5; i++) begin
      send(8'h0B, 4'b1101, {4'b0011, 2'b10});
      drain();
      check("sat_corr_cnt_s", corr_cnt_s, sat_exp[i]);
    end
    check("sat_corr_cnt", corr_cnt, 16'd5);

    // clear coinciding with a double-error delivery
    out_ready = 1'b0;
    send(8'h3C, 4'b1010, {4'hC, 2'b01});
    tick();
    check("held_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    check("clr_hs_corr_s", corr_cnt_s, 2'd0);
    check("clr_hs_uncorr_s", uncorr_cnt_s, 2'd0);
    tick();
    check("clr_hs_uncorr", uncorr_cnt, 16'd0);
    check("clr_hs_corr", corr_cnt, 16'd0);
    check("clr_hs_drained", exp_q.size(), 0);

    // reset with both stages full
    send(8'h2B, 4'b0011, {4'hB, 2'b10});
    drain();
    out_ready = 1'b0;
    send(8'h77, 4'b1101, {4'hF, 2'b10});
    send(8'h88, 4'b0000, {4'h8, 2'b00});
    tick();
    check("full_valid", out_valid, 1'b1);
    check("full_in_ready", in_ready, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_out_data", out_data, 4'h0);
    check("mid_rst_flags", {out_corrected, out_uncorrectable}, 2'b00);
    check("mid_rst_corr_cnt", corr_cnt, 16'd0);
    check("mid_rst_uncorr_cnt", uncorr_cnt, 16'd0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_idle", out_valid, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
